// File: rtl/baser_257b_pkg.sv
// Widths, enums and the shared 257b encoder used by the BASE-R 257b generator and checker.
package baser_257b_pkg;

    localparam int DATA_WIDTH      = 64;
    localparam int TC_DATA_WIDTH   = 4 * DATA_WIDTH;
    localparam int SH_WIDTH        = 1;
    localparam int TC_WIDTH        = TC_DATA_WIDTH + SH_WIDTH;
    localparam int CNT_WIDTH       = 32;

    localparam logic [7:0] DATA_CHAR_PATTERN = 8'hAA;
    localparam logic [7:0] CTRL_CHAR_PATTERN = 8'h55;

    localparam logic [3:0] MASK_ALL_DATA = 4'hF;
    localparam logic [3:0] MASK_ALL_CTRL = 4'h0;
    localparam logic [3:0] MASK_ALT_ODD  = 4'hE;

    typedef enum logic [1:0] {
        MODE_DATA = 2'd0,
        MODE_CTRL = 2'd1,
        MODE_ALT  = 2'd2,
        MODE_USER = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [3:0] block_mask(mode_e mode, logic [3:0] user_mask, logic odd_index);
        logic [3:0] m;
        m = MASK_ALL_DATA;
        case (mode)
            MODE_DATA: m = MASK_ALL_DATA;
            MODE_CTRL: m = MASK_ALL_CTRL;
            MODE_ALT:  m = odd_index ? MASK_ALT_ODD : MASK_ALL_DATA;
            default:   m = user_mask;
        endcase
        return m;
    endfunction

    // The first control block is written as a full 64b word and its top nibble is then
    // overwritten by the next block (or falls into the 4 spare bits when it is last).
    function automatic logic [TC_WIDTH-1:0] build_257b(logic [3:0] mask);
        logic [TC_WIDTH+3:0]   word;
        logic [DATA_WIDTH-1:0] data_blk;
        logic [DATA_WIDTH-1:0] ctrl_blk;
        logic [8:0]            pos;
        logic                  ctrl_seen;
        data_blk  = {8{DATA_CHAR_PATTERN}};
        ctrl_blk  = {8{CTRL_CHAR_PATTERN}};
        word      = '0;
        pos       = 9'd5;
        ctrl_seen = 1'b0;
        if (mask == MASK_ALL_DATA) begin
            word = {4'b0000, {4{data_blk}}, 1'b1};
        end else begin
            word[4:1] = mask;
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) begin
                    word[pos +: DATA_WIDTH] = data_blk;
                    pos = pos + 9'd64;
                end else begin
                    word[pos +: DATA_WIDTH] = ctrl_blk;
                    pos = pos + (ctrl_seen ? 9'd64 : 9'd60);
                    ctrl_seen = 1'b1;
                end
            end
        end
        return word[TC_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/baser_257b_block_builder.sv
// Combinational 257b word builder: block-type mask plus fixed byte patterns -> transcoded word.
module baser_257b_block_builder
    import baser_257b_pkg::*;
(
    input  logic [3:0]          mask_i,
    output logic [TC_WIDTH-1:0] tx_coded_o
);

    assign tx_coded_o = build_257b(mask_i);

endmodule

// File: rtl/baser_257b_generator.sv
// 257b transcoded BASE-R traffic generator: burst FSM, ready/valid output and per-class counters.
// Optional error injection (extra ports i_err_period/o_inj_count) when BASER_257B_ERR_INJECT_EN is defined.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_IDLE | waiting for i_start; o_valid low
//  ST_RUN  | presenting a block each cycle; advances on o_valid&&i_ready
//  ST_DONE | one-cycle o_done pulse, then back to ST_IDLE
module baser_257b_generator
    import baser_257b_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_rst,
`ifdef BASER_257B_ERR_INJECT_EN
    input  logic [15:0]          i_err_period,
    output logic [31:0]          o_inj_count,
`endif
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [1:0]           i_mode,
    input  logic [3:0]           i_ctrl_mask,
    input  logic [31:0]          i_num_blocks,
    input  logic                 i_ready,
    output logic [TC_WIDTH-1:0]  o_tx_coded,
    output logic                 o_valid,
    output logic                 o_done,
    output logic [31:0]          o_block_count,
    output logic [31:0]          o_data_count,
    output logic [31:0]          o_ctrl_count
);

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic [3:0]             user_mask_q, user_mask_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [CNT_WIDTH-1:0]   idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic [3:0]             cur_mask_q, cur_mask_d;
    logic                   cur_inj_q, cur_inj_d;
    logic [TC_WIDTH-1:0]    tx_q, tx_d;
    logic [CNT_WIDTH-1:0]   blk_cnt_q, data_cnt_q, ctrl_cnt_q;

    logic                   accept;
    logic                   last_block;
    logic                   issue_first;
    logic                   issue_next;
    logic [CNT_WIDTH-1:0]   next_idx;
    logic [3:0]             next_mask;
    logic                   next_inj;
    logic [TC_WIDTH-1:0]    built_word;
    logic [TC_WIDTH-1:0]    next_word;

    assign accept     = (state_q == ST_RUN) && i_ready;
    assign last_block = (num_q != '0) && (idx_q == num_q - 32'd1);
    assign next_idx   = (state_q == ST_IDLE) ? '0 : idx_q + 32'd1;

    // In IDLE the first block is built straight from the inputs being captured this cycle.
    always_comb begin
        if (state_q == ST_IDLE) begin
            next_mask = block_mask(mode_e'(i_mode), i_ctrl_mask, 1'b0);
        end else begin
            next_mask = block_mask(mode_q, user_mask_q, next_idx[0]);
        end
    end

    baser_257b_block_builder u_builder (
        .mask_i     (next_mask),
        .tx_coded_o (built_word)
    );

`ifdef BASER_257B_ERR_INJECT_EN
    logic [15:0]          period_q;
    logic [15:0]          err_cnt_q;
    logic [15:0]          next_err_cnt;
    logic [15:0]          active_period;
    logic [CNT_WIDTH-1:0] inj_cnt_q;

    // err_cnt counts down the blocks remaining until the next injected one.
    always_comb begin
        active_period = (state_q == ST_IDLE) ? i_err_period : period_q;
        if (state_q == ST_IDLE) begin
            next_err_cnt = i_err_period - 16'd1;
        end else if (err_cnt_q == '0) begin
            next_err_cnt = period_q - 16'd1;
        end else begin
            next_err_cnt = err_cnt_q - 16'd1;
        end
        next_inj = (active_period != '0) && (next_err_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            period_q  <= '0;
            err_cnt_q <= '0;
        end else if (issue_first) begin
            period_q  <= i_err_period;
            err_cnt_q <= next_err_cnt;
        end else if (issue_next) begin
            err_cnt_q <= next_err_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            inj_cnt_q <= '0;
        end else if (accept && cur_inj_q) begin
            inj_cnt_q <= inj_cnt_q + 32'd1;
        end
    end

    assign o_inj_count = inj_cnt_q;
`else
    assign next_inj = 1'b0;
`endif

    assign next_word = next_inj ? {built_word[TC_WIDTH-1:5], 4'hF, 1'b0} : built_word;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        user_mask_d = user_mask_q;
        num_d       = num_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        cur_mask_d  = cur_mask_q;
        cur_inj_d   = cur_inj_q;
        tx_d        = tx_q;
        issue_first = 1'b0;
        issue_next  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d     = ST_RUN;
                    mode_d      = mode_e'(i_mode);
                    user_mask_d = i_ctrl_mask;
                    num_d       = i_num_blocks;
                    idx_d       = '0;
                    stop_d      = i_stop;
                    issue_first = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_block || stop_q || i_stop) begin
                        state_d = ST_DONE;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d      = next_idx;
                        issue_next = 1'b1;
                    end
                end else if (i_stop) begin
                    stop_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (issue_first || issue_next) begin
            cur_mask_d = next_mask;
            cur_inj_d  = next_inj;
            tx_d       = next_word;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_DATA;
            user_mask_q <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            stop_q      <= 1'b0;
            cur_mask_q  <= '0;
            cur_inj_q   <= 1'b0;
            tx_q        <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            user_mask_q <= user_mask_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            cur_mask_q  <= cur_mask_d;
            cur_inj_q   <= cur_inj_d;
            tx_q        <= tx_d;
        end
    end

    // Injected blocks are deliberately excluded from the data/control classes.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            blk_cnt_q  <= '0;
            data_cnt_q <= '0;
            ctrl_cnt_q <= '0;
        end else if (accept) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
            if (!cur_inj_q) begin
                if (cur_mask_q == MASK_ALL_DATA) begin
                    data_cnt_q <= data_cnt_q + 32'd1;
                end else begin
                    ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
                end
            end
        end
    end

    assign o_tx_coded    = tx_q;
    assign o_valid       = (state_q == ST_RUN);
    assign o_done        = (state_q == ST_DONE);
    assign o_block_count = blk_cnt_q;
    assign o_data_count  = data_cnt_q;
    assign o_ctrl_count  = ctrl_cnt_q;

endmodule

// File: tb/tb_baser_257b_generator.sv
// Self-checking bench for baser_257b_generator: encoding table, handshake/burst sequences, random bursts.
module tb_baser_257b_generator;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic         i_stop;
    logic [1:0]   i_mode;
    logic [3:0]   i_ctrl_mask;
    logic [31:0]  i_num_blocks;
    logic         i_ready;
    logic [256:0] o_tx_coded;
    logic         o_valid;
    logic         o_done;
    logic [31:0]  o_block_count;
    logic [31:0]  o_data_count;
    logic [31:0]  o_ctrl_count;
`ifdef BASER_257B_ERR_INJECT_EN
    logic [15:0]  err_period;
    logic [31:0]  o_inj_count;
`endif

    always #5 clk = ~clk;

    baser_257b_generator dut (
        .clk           (clk),
        .i_rst         (i_rst),
`ifdef BASER_257B_ERR_INJECT_EN
        .i_err_period  (err_period),
        .o_inj_count   (o_inj_count),
`endif
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_mode        (i_mode),
        .i_ctrl_mask   (i_ctrl_mask),
        .i_num_blocks  (i_num_blocks),
        .i_ready       (i_ready),
        .o_tx_coded    (o_tx_coded),
        .o_valid       (o_valid),
        .o_done        (o_done),
        .o_block_count (o_block_count),
        .o_data_count  (o_data_count),
        .o_ctrl_count  (o_ctrl_count)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_blk = 0, exp_data = 0, exp_ctrl = 0, exp_inj = 0;
    logic [256:0] first_word;

    typedef struct {
        logic [1:0]   mode;
        logic [3:0]   cmask;
        logic [256:0] word;
        bit           is_data;
    } vec_t;
    vec_t tab[8];

    task automatic chk(input string nm, input logic [256:0] act, input logic [256:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_counts();
        chk("block_count", 257'(o_block_count), 257'(exp_blk));
        chk("data_count", 257'(o_data_count), 257'(exp_data));
        chk("ctrl_count", 257'(o_ctrl_count), 257'(exp_ctrl));
`ifdef BASER_257B_ERR_INJECT_EN
        chk("inj_count", 257'(o_inj_count), 257'(exp_inj));
`endif
    endtask

    function automatic logic [3:0] ref_mask(logic [1:0] mode, logic [3:0] cm, int idx);
        case (mode)
            2'd0: return 4'hF;
            2'd1: return 4'h0;
            2'd2: return (idx % 2 == 1) ? 4'hE : 4'hF;
            default: return cm;
        endcase
    endfunction

    // Payload as a bit stream appended segment by segment above the 5 header bits.
    function automatic logic [256:0] ref_word(logic [3:0] m);
        logic [260:0] w;
        logic [260:0] seg;
        int pos;
        int len;
        bit first;
        if (m == 4'hF) return {{32{8'hAA}}, 1'b1};
        w = 261'(m) << 1;
        pos = 5;
        first = 1;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                seg = 261'({8{8'hAA}});
                len = 64;
            end else begin
                len = first ? 60 : 64;
                seg = 261'({8{8'h55}}) & ~(~261'd0 << len);
                first = 0;
            end
            w = w | (seg << pos);
            pos += len;
        end
        return w[256:0];
    endfunction

    // rdy_pat: 0 always ready, 1 ready on odd cycles, 2 random ready plus stray i_start pulses.
    task automatic burst(input logic [1:0] mode, input logic [3:0] cm, input logic [31:0] num,
                         input int rdy_pat, input int stop_cyc, input bit stop_w_start, input int per);
        int idx = 0;
        bit stalled = 0;
        bit stop_pend = stop_w_start;
        bit fin = 0;
        bit last = 0;
        bit inj;
        logic [3:0] m;
        logic [256:0] expw;
        @(negedge clk);
        i_start = 1; i_stop = stop_w_start; i_mode = mode; i_ctrl_mask = cm; i_num_blocks = num;
`ifdef BASER_257B_ERR_INJECT_EN
        err_period = 16'(per);
`endif
        @(negedge clk);
        i_start = 0; i_stop = 0;
        i_mode = 2'($urandom); i_ctrl_mask = 4'($urandom); i_num_blocks = $urandom;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            chk_counts();
            if (last) begin
                chk("done_pulse", 257'(o_done), 257'(1));
                chk("valid_in_done", 257'(o_valid), 257'(0));
                @(negedge clk);
                chk("done_width", 257'(o_done), 257'(0));
                chk("valid_after_done", 257'(o_valid), 257'(0));
                fin = 1;
            end else begin
                m = ref_mask(mode, cm, idx);
                inj = (per != 0) && ((idx + 1) % per == 0);
                expw = ref_word(m);
                if (inj) expw = {expw[256:5], 4'hF, 1'b0};
                chk("valid_run", 257'(o_valid), 257'(1));
                chk("no_early_done", 257'(o_done), 257'(0));
                chk(stalled ? "stall_stable" : "word", o_tx_coded, expw);
                if (idx == 0 && !stalled) first_word = o_tx_coded;
                i_ready = (rdy_pat == 0) ? 1'b1 : (rdy_pat == 1) ? 1'(cyc % 2 == 1) : 1'($urandom % 4 != 0);
                i_stop = (cyc == stop_cyc);
                i_start = (rdy_pat == 2) ? 1'($urandom % 2) : 1'b0;
                if (i_stop) stop_pend = 1;
                if (i_ready) begin
                    exp_blk++;
                    if (inj) exp_inj++;
                    else if (m == 4'hF) exp_data++;
                    else exp_ctrl++;
                    idx++;
                    stalled = 0;
                    if (stop_pend || (num != 0 && idx == num)) last = 1;
                end else begin
                    stalled = 1;
                end
                @(negedge clk);
                i_stop = 0; i_start = 0;
            end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL burst_timeout actual=no_done required=done");
        end
        i_ready = 1;
    endtask

    task automatic do_reset();
        i_rst = 1;
        repeat (3) @(negedge clk);
        i_rst = 0;
        exp_blk = 0; exp_data = 0; exp_ctrl = 0; exp_inj = 0;
    endtask

    logic [31:0] b0, d0, c0;

    initial begin
        tab[0] = '{2'd0, 4'h0, {{32{8'hAA}}, 1'b1}, 1'b1};
        tab[1] = '{2'd1, 4'h0, {{63{4'h5}}, 4'h0, 1'b0}, 1'b0};
        tab[2] = '{2'd2, 4'h0, {{32{8'hAA}}, 1'b1}, 1'b1};
        tab[3] = '{2'd3, 4'hE, {{24{8'hAA}}, {15{4'h5}}, 4'hE, 1'b0}, 1'b0};
        tab[4] = '{2'd3, 4'h7, {{15{4'h5}}, {24{8'hAA}}, 4'h7, 1'b0}, 1'b0};
        tab[5] = '{2'd3, 4'h5, {{8{8'h55}}, {8{8'hAA}}, {15{4'h5}}, {8{8'hAA}}, 4'h5, 1'b0}, 1'b0};
        tab[6] = '{2'd3, 4'hA, {{8{8'hAA}}, {8{8'h55}}, {8{8'hAA}}, {15{4'h5}}, 4'hA, 1'b0}, 1'b0};
        tab[7] = '{2'd3, 4'hF, {{32{8'hAA}}, 1'b1}, 1'b1};

        i_start = 0; i_stop = 0; i_mode = 0; i_ctrl_mask = 0; i_num_blocks = 0; i_ready = 1;
`ifdef BASER_257B_ERR_INJECT_EN
        err_period = 0;
`endif
        do_reset();
        chk("rst_tx", o_tx_coded, '0);
        chk("rst_valid", 257'(o_valid), 257'(0));
        chk("rst_done", 257'(o_done), 257'(0));
        chk_counts();

        // Four all-data blocks at full rate.
        burst(2'd0, 4'h0, 32'd4, 0, -1, 0, 0);
        chk("t1_blocks", 257'(o_block_count), 257'(4));
        chk("t1_data", 257'(o_data_count), 257'(4));
        chk("t1_ctrl", 257'(o_ctrl_count), 257'(0));

        for (int i = 0; i < 8; i++) begin
            d0 = exp_data; c0 = exp_ctrl;
            burst(tab[i].mode, tab[i].cmask, 32'd1, 0, -1, 0, 0);
            chk($sformatf("tab%0d_word", i), first_word, tab[i].word);
            chk($sformatf("tab%0d_data_delta", i), 257'(o_data_count - d0), 257'(tab[i].is_data ? 1 : 0));
            chk($sformatf("tab%0d_ctrl_delta", i), 257'(o_ctrl_count - c0), 257'(tab[i].is_data ? 0 : 1));
        end

        // Alternating mode under toggling backpressure.
        b0 = exp_blk; d0 = exp_data; c0 = exp_ctrl;
        burst(2'd2, 4'h0, 32'd6, 1, -1, 0, 0);
        chk("t3_blocks", 257'(o_block_count - b0), 257'(6));
        chk("t3_data", 257'(o_data_count - d0), 257'(3));
        chk("t3_ctrl", 257'(o_ctrl_count - c0), 257'(3));

        // Continuous burst stopped while stalled at cycle 10.
        b0 = exp_blk;
        burst(2'd1, 4'h0, 32'd0, 1, 10, 0, 0);
        chk("t4_blocks", 257'(o_block_count - b0), 257'(6));

        // Start and stop together: exactly one block.
        b0 = exp_blk;
        burst(2'd3, 4'h5, 32'd0, 0, -1, 1, 0);
        chk("start_stop_blocks", 257'(o_block_count - b0), 257'(1));

        for (int r = 0; r < 24; r++) begin
            logic [31:0] n;
            int sc;
            n = 32'($urandom_range(0, 6));
            sc = (n == 0) ? int'($urandom_range(0, 12)) : (($urandom % 3 == 0) ? int'($urandom_range(0, 12)) : -1);
            burst(2'($urandom), 4'($urandom), n, 2, sc, 1'($urandom % 8 == 0), 0);
        end

        // Reset in the middle of a burst, while block 3 is presented.
        @(negedge clk);
        i_start = 1; i_mode = 2'd0; i_num_blocks = 32'd10; i_ready = 1;
        @(negedge clk);
        i_start = 0;
        repeat (3) @(negedge clk);
        chk("t5_valid_before_rst", 257'(o_valid), 257'(1));
        i_rst = 1;
        @(negedge clk);
        i_rst = 0;
        exp_blk = 0; exp_data = 0; exp_ctrl = 0; exp_inj = 0;
        chk("t5_tx", o_tx_coded, '0);
        chk("t5_valid", 257'(o_valid), 257'(0));
        chk_counts();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_no_done", 257'(o_done), 257'(0));
        end
        burst(2'd1, 4'h0, 32'd2, 0, -1, 0, 0);
        chk("t5_fresh_blocks", 257'(o_block_count), 257'(2));
        chk("t5_fresh_ctrl", 257'(o_ctrl_count), 257'(2));

`ifdef BASER_257B_ERR_INJECT_EN
        b0 = exp_blk; d0 = exp_data; c0 = exp_ctrl;
        begin
            logic [31:0] inj0;
            inj0 = exp_inj;
            burst(2'd0, 4'h0, 32'd9, 0, -1, 0, 3);
            chk("t6_inj", 257'(o_inj_count - inj0), 257'(3));
        end
        chk("t6_blocks", 257'(o_block_count - b0), 257'(9));
        chk("t6_data_ctrl", 257'((o_data_count - d0) + (o_ctrl_count - c0)), 257'(6));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
